// File: rtl/ft232r_rsp_arb.sv
// Round-robin arbiter sharing the FT232R response byte path among P_N_REQ 4-phase requesters.
// Optional build macro FT232R_RSP_ARB_TIMEOUT_EN adds an rsp_ack timeout with timeout_err pulse.
module ft232r_rsp_arb #(
    parameter int unsigned P_N_REQ          = 4,
    parameter int unsigned P_TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [P_N_REQ-1:0]   src_req,
    input  logic [8*P_N_REQ-1:0] src_data,
    output logic [P_N_REQ-1:0]   src_ack,
    output logic                 rsp_req,
    input  logic                 rsp_ack,
    output logic [7:0]           rsp_data,
    output logic [P_N_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int unsigned IW = $clog2(P_N_REQ);

    if (P_N_REQ < 2 || P_N_REQ > 8 || P_TIMEOUT_CYCLES < 1 || P_TIMEOUT_CYCLES > 65535)
    begin : g_param_check
        $error("ft232r_rsp_arb: parameter out of range");
    end

    typedef enum logic [1:0] {StIdle, StSend, StRel} state_t;

    state_t             state;
    logic [IW-1:0]      ptr;
    logic [IW-1:0]      sel;
    logic [IW-1:0]      sel_next;
    logic [P_N_REQ-1:0] sel_onehot;
    logic               sel_found;

`ifdef FT232R_RSP_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(P_TIMEOUT_CYCLES - 1);
    logic [15:0] to_cnt;
`endif

    // First asserted requester strictly after ptr, wrapping modulo P_N_REQ.
    always_comb begin
        int unsigned   idx;
        logic [IW-1:0] idx_w;
        idx        = 0;
        idx_w      = '0;
        sel_found  = 1'b0;
        sel_next   = '0;
        sel_onehot = '0;
        for (int unsigned i = 1; i <= P_N_REQ; i++) begin
            idx   = (32'(ptr) + i) % P_N_REQ;
            idx_w = IW'(idx);
            if (!sel_found && src_req[idx_w]) begin
                sel_found         = 1'b1;
                sel_next          = idx_w;
                sel_onehot[idx_w] = 1'b1;
            end
        end
    end

    assign busy = (state != StIdle);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StIdle;
            ptr      <= IW'(P_N_REQ - 1);
            sel      <= '0;
            grant    <= '0;
            src_ack  <= '0;
            rsp_req  <= 1'b0;
            rsp_data <= '0;
`ifdef FT232R_RSP_ARB_TIMEOUT_EN
            to_cnt      <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
`ifdef FT232R_RSP_ARB_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            unique case (state)
                StIdle: begin
                    if (sel_found) begin
                        state    <= StSend;
                        sel      <= sel_next;
                        grant    <= sel_onehot;
                        rsp_data <= src_data[8*sel_next +: 8];
                        rsp_req  <= 1'b1;
`ifdef FT232R_RSP_ARB_TIMEOUT_EN
                        to_cnt   <= '0;
`endif
                    end
                end
                StSend: begin
                    // rsp_ack wins over a coincident timeout.
                    if (rsp_ack) begin
                        rsp_req      <= 1'b0;
                        src_ack[sel] <= 1'b1;
                        state        <= StRel;
                    end
`ifdef FT232R_RSP_ARB_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        timeout_err  <= 1'b1;
                        rsp_req      <= 1'b0;
                        src_ack[sel] <= 1'b1;
                        state        <= StRel;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
`endif
                end
                StRel: begin
                    if (!src_req[sel]) begin
                        src_ack <= '0;
                        ptr     <= sel;
                        grant   <= '0;
                        state   <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifndef FT232R_RSP_ARB_TIMEOUT_EN
    assign timeout_err = 1'b0;
`endif

endmodule
